// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, issues single-outstanding
// requests to instruction memory, buffers returned words in a small prefetch
// queue and presents {pc, instr, exc} to decode. Redirects and exception
// entry flush the queue and restart fetching at the new target.
// Optional: define FETCH_PERF_EN to count decode bubbles on perf_bubbles.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] EXC_PC   = 32'h0000_4180,
  parameter int unsigned QDEPTH   = 2,
  parameter logic [31:0] IM_LO    = 32'h0000_3000,
  parameter logic [31:0] IM_HI    = 32'h0000_6FFC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        exc_req,
  output logic        im_req,
  output logic [31:0] im_addr,
  input  logic        im_gnt,
  input  logic        im_rvalid,
  input  logic [31:0] im_rdata,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_instr,
  output logic [4:0]  id_exc,
  input  logic        id_ready,
  output logic [31:0] perf_bubbles
);

  localparam int unsigned AW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int unsigned CW = $clog2(QDEPTH) + 1;

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_EXC_HOLD} state_t;

  state_t        state, state_nxt;
  logic [31:0]   fetch_pc;
  logic [31:0]   req_pc;
  logic          outstanding;
  logic          drop;

  logic [31:0]   q_pc    [QDEPTH];
  logic [31:0]   q_instr [QDEPTH];
  logic [4:0]    q_exc   [QDEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;

  logic          flush, pc_legal, room, can_issue;
  logic          gnt_fire, rv_fire, push_rv, push_exc, push, pop;
  logic [31:0]   push_pc, push_instr;
  logic [4:0]    push_code;

  assign flush     = redirect | exc_req;
  assign pc_legal  = (fetch_pc[1:0] == 2'b00) && (fetch_pc >= IM_LO) && (fetch_pc <= IM_HI);
  assign room      = (count + CW'(outstanding)) < CW'(QDEPTH);
  assign can_issue = !reset && !outstanding && room;
  assign gnt_fire  = im_req & im_gnt;
  assign rv_fire   = outstanding & im_rvalid;
  // A response is kept only for a live request and never in a flush cycle.
  assign push_rv   = rv_fire & !drop & !flush;
  assign push      = push_rv | push_exc;
  assign pop       = id_valid & id_ready & !flush;
  assign push_pc    = push_rv ? req_pc   : fetch_pc;
  assign push_instr = push_rv ? im_rdata : '0;
  assign push_code  = push_rv ? 5'd0     : 5'd4;

  assign im_addr  = fetch_pc;
  assign id_valid = (count != '0);
  assign id_pc    = id_valid ? q_pc[rd_ptr]    : '0;
  assign id_instr = id_valid ? q_instr[rd_ptr] : '0;
  assign id_exc   = id_valid ? q_exc[rd_ptr]   : '0;

  // Next-state and request/exception-push decode.
  always_comb begin
    state_nxt = state;
    im_req    = 1'b0;
    push_exc  = 1'b0;
    case (state)
      S_REQ: begin
        if (can_issue) begin
          if (pc_legal) begin
            im_req = 1'b1;
            if (im_gnt) state_nxt = S_WAIT;
          end else begin
            push_exc  = !flush;
            state_nxt = S_EXC_HOLD;
          end
        end
      end
      S_WAIT:     if (rv_fire) state_nxt = S_REQ;
      S_EXC_HOLD: state_nxt = S_EXC_HOLD;
      default:    state_nxt = S_REQ;
    endcase
    if (flush) state_nxt = S_REQ;
  end

  // Fetch PC, outstanding-request tracking and the drop flag.
  // outstanding survives a flush (state returns to S_REQ) so that the stale
  // response can still be absorbed; drop marks it for discarding.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_REQ;
      fetch_pc    <= RESET_PC;
      req_pc      <= '0;
      outstanding <= 1'b0;
      drop        <= 1'b0;
    end else begin
      state <= state_nxt;
      if (exc_req)       fetch_pc <= EXC_PC;
      else if (redirect) fetch_pc <= redirect_pc;
      else if (gnt_fire) fetch_pc <= fetch_pc + 32'd4;
      if (gnt_fire) req_pc <= fetch_pc;
      if (gnt_fire)     outstanding <= 1'b1;
      else if (rv_fire) outstanding <= 1'b0;
      if (flush && (gnt_fire || (outstanding && !im_rvalid))) drop <= 1'b1;
      else if (rv_fire)                                       drop <= 1'b0;
    end
  end

  // Queue pointers and occupancy; a flush empties the queue.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Queue storage write.
  always_ff @(posedge clk) begin
    if (push) begin
      q_pc[wr_ptr]    <= push_pc;
      q_instr[wr_ptr] <= push_instr;
      q_exc[wr_ptr]   <= push_code;
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] bubbles;

  // Saturating count of cycles where decode was ready but starved.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      bubbles <= '0;
    else if (id_ready && !id_valid && (bubbles != '1))
      bubbles <= bubbles + 32'd1;
  end

  assign perf_bubbles = bubbles;
`else
  assign perf_bubbles = '0;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: directed sequences, a vector table
// of redirect/exception targets, and randomized traffic checked against a
// stream-level reference model (requests and decode entries follow target,
// target+4, ... until an illegal address yields one AdEL entry).
module tb_if_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam logic [31:0] EXC_PC   = 32'h0000_4180;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        exc_req;
  logic        im_req;
  logic [31:0] im_addr;
  logic        im_gnt;
  logic        im_rvalid;
  logic [31:0] im_rdata;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_instr;
  logic [4:0]  id_exc;
  logic        id_ready;
  logic [31:0] perf_bubbles;

  if_fetch_unit #(
    .RESET_PC(RESET_PC), .EXC_PC(EXC_PC), .QDEPTH(2),
    .IM_LO(32'h0000_3000), .IM_HI(32'h0000_6FFC)
  ) dut (
    .clk(clk), .reset(reset), .redirect(redirect), .redirect_pc(redirect_pc),
    .exc_req(exc_req), .im_req(im_req), .im_addr(im_addr), .im_gnt(im_gnt),
    .im_rvalid(im_rvalid), .im_rdata(im_rdata), .id_valid(id_valid),
    .id_pc(id_pc), .id_instr(id_instr), .id_exc(id_exc), .id_ready(id_ready),
    .perf_bubbles(perf_bubbles)
  );

  initial forever #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // memory responder state
  int unsigned gnt_pct = 100;
  int unsigned lat     = 1;
  logic        pending = 1'b0;
  int unsigned pend_cnt = 0;
  logic [31:0] pend_addr = '0;

  // sampled DUT view
  logic        s_req, s_gnt, s_rv, s_valid, s_rdy;
  logic [31:0] s_addr, s_pc, s_instr;
  logic [4:0]  s_exc;

  // reference model
  logic [31:0] m_req_pc = RESET_PC;
  logic [31:0] m_pop_pc = RESET_PC;
  logic        m_dead = 1'b0;
  logic        after_flush = 1'b0;
  int          pops = 0;

  function automatic logic [31:0] mw(input logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  function automatic logic is_legal(input logic [31:0] a);
    return (a[1:0] == 2'b00) && (a >= 32'h0000_3000) && (a <= 32'h0000_6FFC);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input logic fl);
    if (after_flush) chk("flush_empties_queue", 32'(s_valid), 32'd0);
    after_flush = 1'b0;
    if (s_req) begin
      chk("req_addr", s_addr, m_req_pc);
      if (!is_legal(m_req_pc)) chk("req_on_illegal_pc", 32'(s_req), 32'd0);
    end
    if (s_gnt) m_req_pc = m_req_pc + 32'd4;
    if (s_valid && s_rdy && !fl) begin
      pops++;
      if (m_dead) chk("pop_after_adel", 32'(s_valid), 32'd0);
      chk("pop_pc", s_pc, m_pop_pc);
      if (is_legal(m_pop_pc)) begin
        chk("pop_instr", s_instr, mw(m_pop_pc));
        chk("pop_exc", 32'(s_exc), 32'd0);
      end else begin
        chk("pop_instr_adel", s_instr, 32'd0);
        chk("pop_exc_adel", 32'(s_exc), 32'd4);
        m_dead = 1'b1;
      end
      m_pop_pc = m_pop_pc + 32'd4;
    end
    if (fl) begin
      m_req_pc    = exc_req ? EXC_PC : redirect_pc;
      m_pop_pc    = m_req_pc;
      m_dead      = 1'b0;
      after_flush = 1'b1;
    end
  endtask

  // One clock cycle: called at posedge+1 with this cycle's inputs set.
  task automatic cycle();
    logic fl;
    #1;
    fl        = redirect | exc_req;
    im_rvalid = pending && (pend_cnt == 0);
    im_rdata  = im_rvalid ? mw(pend_addr) : $urandom;
    im_gnt    = !fl && im_req && ($urandom_range(0, 99) < gnt_pct);
    #3;
    s_req = im_req;   s_addr  = im_addr;  s_gnt = im_gnt;  s_rv  = im_rvalid;
    s_valid = id_valid; s_pc = id_pc; s_instr = id_instr; s_exc = id_exc;
    s_rdy = id_ready;
    if (!reset) model_step(fl);
    @(posedge clk);
    if (s_gnt) chk("one_outstanding", 32'(pending && !s_rv), 32'd0);
    if (s_rv) pending = 1'b0;
    else if (pending) pend_cnt--;
    if (s_gnt) begin
      pending   = 1'b1;
      pend_cnt  = lat - 1;
      pend_addr = s_addr;
    end
    #1;
  endtask

  task automatic hit_reset();
    reset = 1'b1;
    cycle();
    reset       = 1'b0;
    m_req_pc    = RESET_PC;
    m_pop_pc    = RESET_PC;
    m_dead      = 1'b0;
    after_flush = 1'b0;
  endtask

  typedef struct {
    logic [31:0] tgt;
    logic        use_redir;
    logic        use_exc;
    logic        exp_req;
    logic [31:0] exp_pc;
    logic [31:0] exp_instr;
    logic [4:0]  exp_exc;
    int          lat;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic found;
    int   nreq;
    int   r;

    vecs[0] = '{32'h0000_3100, 1'b1, 1'b0, 1'b1, 32'h0000_3100, mw(32'h0000_3100), 5'd0, 2};
    vecs[1] = '{32'h0000_3002, 1'b1, 1'b0, 1'b0, 32'h0000_3002, 32'h0,             5'd4, 1};
    vecs[2] = '{32'h0000_0000, 1'b0, 1'b1, 1'b1, EXC_PC,        mw(EXC_PC),        5'd0, 2};
    vecs[3] = '{32'h0000_3200, 1'b1, 1'b1, 1'b1, EXC_PC,        mw(EXC_PC),        5'd0, 2};
    vecs[4] = '{32'h0000_2FFC, 1'b1, 1'b0, 1'b0, 32'h0000_2FFC, 32'h0,             5'd4, 1};
    vecs[5] = '{32'h0000_7000, 1'b1, 1'b0, 1'b0, 32'h0000_7000, 32'h0,             5'd4, 1};
    vecs[6] = '{32'h0000_6FFC, 1'b1, 1'b0, 1'b1, 32'h0000_6FFC, mw(32'h0000_6FFC), 5'd0, 2};
    vecs[7] = '{32'h0000_3000, 1'b1, 1'b0, 1'b1, 32'h0000_3000, mw(32'h0000_3000), 5'd0, 2};

    reset = 1'b1; redirect = 1'b0; redirect_pc = '0; exc_req = 1'b0;
    im_gnt = 1'b0; im_rvalid = 1'b0; im_rdata = '0; id_ready = 1'b0;

    // reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_im_req", 32'(im_req), 32'd0);
    chk("rst_id_valid", 32'(id_valid), 32'd0);
    chk("rst_id_pc", id_pc, 32'd0);
    chk("rst_id_instr", id_instr, 32'd0);
    chk("rst_id_exc", 32'(id_exc), 32'd0);
    chk("rst_perf", perf_bubbles, 32'd0);
    reset = 1'b0;

    // streaming after reset: gnt every cycle, rvalid one cycle later
    id_ready = 1'b1; gnt_pct = 100; lat = 1;
    cycle();
    chk("a_req0", 32'(s_req), 32'd1);
    chk("a_addr0", s_addr, 32'h0000_3000);
    cycle();
    chk("a_latency_empty", 32'(s_valid), 32'd0);
    cycle();
    chk("a_valid1", 32'(s_valid), 32'd1);
    chk("a_pc1", s_pc, 32'h0000_3000);
    chk("a_exc1", 32'(s_exc), 32'd0);
    chk("a_addr1", s_addr, 32'h0000_3004);
    cycle();
    cycle();
    chk("a_pc2", s_pc, 32'h0000_3004);

    // backpressure: queue fills to two, requests stop, then drain in order
    id_ready = 1'b0;
    repeat (6) cycle();
    chk("b_full_no_req", 32'(s_req), 32'd0);
    chk("b_full_valid", 32'(s_valid), 32'd1);
    chk("b_head_pc", s_pc, 32'h0000_3008);
    id_ready = 1'b1;
    cycle();
    chk("b_drain0", s_pc, 32'h0000_3008);
    cycle();
    chk("b_drain1_valid", 32'(s_valid), 32'd1);
    chk("b_drain1", s_pc, 32'h0000_300C);

    // redirect while a request is outstanding
    lat = 3; found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      cycle();
      if (s_gnt) found = 1'b1;
    end
    chk("c_grant_seen", 32'(found), 32'd1);
    redirect = 1'b1; redirect_pc = 32'h0000_3100; id_ready = 1'b0;
    cycle();
    redirect = 1'b0;
    cycle();
    chk("c_no_req_while_drop", 32'(s_req), 32'd0);
    cycle();
    chk("c_no_req_at_late_rvalid", 32'(s_req), 32'd0);
    cycle();
    chk("c_req_after_drop", 32'(s_req), 32'd1);
    chk("c_addr_after_drop", s_addr, 32'h0000_3100);
    id_ready = 1'b1; lat = 1; found = 1'b0;
    for (int k = 0; k < 12 && !found; k++) begin
      cycle();
      if (s_valid) found = 1'b1;
    end
    chk("c_entry_seen", 32'(found), 32'd1);
    chk("c_first_pc", s_pc, 32'h0000_3100);
    chk("c_first_instr", s_instr, mw(32'h0000_3100));

    // vector table: flush targets, first request and first decode entry
    for (int i = 0; i < 8; i++) begin
      id_ready = 1'b0; gnt_pct = 100; lat = 1; nreq = 0;
      repeat (6) begin
        cycle();
        if (s_req) nreq++;
      end
      if (i > 0 && vecs[i-1].exp_exc == 5'd4) chk("hold_no_req", 32'(nreq), 32'd0);
      redirect = vecs[i].use_redir; exc_req = vecs[i].use_exc; redirect_pc = vecs[i].tgt;
      cycle();
      redirect = 1'b0; exc_req = 1'b0;
      cycle();
      chk("v_flushed", 32'(s_valid), 32'd0);
      chk("v_req", 32'(s_req), 32'(vecs[i].exp_req));
      if (vecs[i].exp_req) chk("v_addr", s_addr, vecs[i].exp_pc);
      for (int k = 1; k <= vecs[i].lat; k++) begin
        cycle();
        if (k < vecs[i].lat) chk("v_not_yet", 32'(s_valid), 32'd0);
        else begin
          chk("v_valid", 32'(s_valid), 32'd1);
          chk("v_pc", s_pc, vecs[i].exp_pc);
          chk("v_instr", s_instr, vecs[i].exp_instr);
          chk("v_exc", 32'(s_exc), 32'(vecs[i].exp_exc));
        end
      end
    end

    // reset mid-transaction; the stale rvalid must be ignored
    id_ready = 1'b1; gnt_pct = 100; lat = 4; found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      cycle();
      if (s_gnt) found = 1'b1;
    end
    chk("e_grant_seen", 32'(found), 32'd1);
    gnt_pct = 0;
    hit_reset();
    for (int k = 0; k < 6; k++) begin
      cycle();
      chk("e_stale_rvalid_ignored", 32'(s_valid), 32'd0);
    end
    chk("e_req_reset_pc", s_addr, RESET_PC);
    chk("e_req_after_reset", 32'(s_req), 32'd1);

    // bubble counter: five starved cycles after reset
    id_ready = 1'b0; gnt_pct = 0; lat = 1;
    hit_reset();
    id_ready = 1'b1;
    repeat (5) cycle();
`ifdef FETCH_PERF_EN
    chk("perf_bubbles", perf_bubbles, 32'd5);
`else
    chk("perf_bubbles_off", perf_bubbles, 32'd0);
`endif

    // randomized traffic against the stream model
    pops = 0;
    for (int n = 0; n < 3000; n++) begin
      lat = $urandom_range(1, 3); gnt_pct = 60;
      id_ready = ($urandom_range(0, 3) != 0);
      redirect = 1'b0; exc_req = 1'b0;
      if ($urandom_range(0, 99) < 4) begin
        id_ready = 1'b0;
        redirect = 1'b1;
        redirect_pc = 32'h0000_3000 + 32'($urandom_range(0, 32'hFFF)) * 32'd4;
        r = $urandom_range(0, 7);
        case (r)
          0: begin exc_req = 1'b1; redirect = $urandom_range(0, 1) != 0; end
          1: redirect_pc = redirect_pc | 32'h2;
          2: redirect_pc = 32'h0000_6FF0;
          3: redirect_pc = $urandom;
          default: ;
        endcase
      end
      cycle();
    end
    redirect = 1'b0; exc_req = 1'b0;
    chk("rand_progress", 32'(pops >= 200), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
